// File: rtl/wb_rom_arb2_if.sv
// Wishbone signal bundle between two masters, the arbiter and the boot ROM.
// The arbiter uses the slave modport; the environment driving the masters and ROM uses master.
`timescale 1ns/1ps
interface wb_rom_arb2_if #(
  parameter int AW = 32
);
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [15:0]   m0_dat_i;
  logic [1:0]    m0_sel_i;
  logic [15:0]   m0_dat_o;
  logic          m0_ack_o, m0_err_o;

  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [15:0]   m1_dat_i;
  logic [1:0]    m1_sel_i;
  logic [15:0]   m1_dat_o;
  logic          m1_ack_o, m1_err_o;

  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [15:0]   s_dat_o;
  logic [1:0]    s_sel_o;
  logic [15:0]   s_dat_i;
  logic          s_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    input  s_dat_i, s_ack_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    output s_dat_i, s_ack_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
endinterface

// File: rtl/wb_rom_arb2.sv
// Two-master Wishbone arbiter in front of the boot ROM, with an ack watchdog.
// Define WB_ROM_ARB_RR_EN for round-robin tie-breaking; otherwise master 0 wins ties.
//
// state | meaning
// IDLE  | no owner, slave side held quiet
// OWN0  | master 0 owns the ROM
// OWN1  | master 1 owns the ROM
// ERR   | watchdog expired, one-cycle err to the last owner
`timescale 1ns/1ps
module wb_rom_arb2 #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  wb_rom_arb2_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ERR} state_t;

  localparam logic [7:0] WDOG_TRIP = 8'(TIMEOUT - 1);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_wdog, w_wdog_nxt, w_wdog_inc;
  logic          r_last_grant, w_last_grant_nxt;
  logic          w_tie_pick1, w_own_cyc, w_own_stb;
  logic [AW-1:0] w_adr;

`ifdef WB_ROM_ARB_RR_EN
  assign w_tie_pick1 = ~r_last_grant;
`else
  assign w_tie_pick1 = 1'b0;
`endif

  assign w_own_cyc = (r_state == OWN1) ? bus.m1_cyc_i : bus.m0_cyc_i;
  assign w_own_stb = (r_state == OWN1) ? bus.m1_stb_i : bus.m0_stb_i;
  assign w_wdog_inc = r_wdog + 8'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_wdog       <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_wdog       <= w_wdog_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_wdog_nxt       = r_wdog;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        w_wdog_nxt = '0;
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          w_state_nxt      = w_tie_pick1 ? OWN1 : OWN0;
          w_last_grant_nxt = w_tie_pick1;
        end else if (bus.m0_cyc_i) begin
          w_state_nxt      = OWN0;
          w_last_grant_nxt = 1'b0;
        end else if (bus.m1_cyc_i) begin
          w_state_nxt      = OWN1;
          w_last_grant_nxt = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!w_own_cyc) begin
          w_state_nxt = IDLE;
          w_wdog_nxt  = '0;
        end else if (bus.s_ack_i) begin
          // an ack in the trip cycle still completes the beat
          w_wdog_nxt = '0;
        end else if (w_own_stb) begin
          w_wdog_nxt = w_wdog_inc;
          if (w_wdog_inc == WDOG_TRIP) w_state_nxt = ERR;
        end
      end
      ERR: begin
        w_state_nxt = IDLE;
        w_wdog_nxt  = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    w_adr        = '0;
    bus.s_dat_o  = '0;
    bus.s_sel_o  = '0;
    bus.m0_ack_o = 1'b0;
    bus.m1_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m1_err_o = 1'b0;
    case (r_state)
      OWN0: begin
        bus.s_cyc_o  = bus.m0_cyc_i;
        bus.s_stb_o  = bus.m0_stb_i;
        bus.s_we_o   = bus.m0_we_i;
        w_adr        = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.m0_ack_o = bus.s_ack_i;
      end
      OWN1: begin
        bus.s_cyc_o  = bus.m1_cyc_i;
        bus.s_stb_o  = bus.m1_stb_i;
        bus.s_we_o   = bus.m1_we_i;
        w_adr        = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.m1_ack_o = bus.s_ack_i;
      end
      ERR: begin
        bus.m0_err_o = ~r_last_grant;
        bus.m1_err_o = r_last_grant;
      end
      default: ;
    endcase
  end

  assign bus.s_adr_o = w_adr;

  // read data is shared; zeroed in reset so every output is quiet
  assign bus.m0_dat_o = rst_n_i ? bus.s_dat_i : 16'h0000;
  assign bus.m1_dat_o = rst_n_i ? bus.s_dat_i : 16'h0000;
endmodule
